key_ctrl_reg: RTL and testbench
===============================

# key_ctrl_reg

Control-state register stage that turns debounced single-cycle key pulses and the player's end-of-song pulse into the held settings `order_reg`, `music_reg`, `volume_reg`, `speed_reg` and `play_reg`. It sits directly upstream of `output_flag`, which decodes these registers into LED and display flags. It also issues a one-cycle `song_start` pulse to the audio player whenever a track is (re)started.

## Interface
- `NUM_SONGS`, 3: highest valid `music_reg` value; 1..NUM_SONGS are tracks, 0 means no track selected.
- `VOL_DEFAULT`, 3: `volume_reg` after reset, range 1..5.
- `IDLE_CYCLES`, 50_000_000: paused-idle timeout in clocks; used only with the macro.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `key_order` in 1: pulse; toggles the play order.
- `key_next` in 1: pulse; selects the next track.
- `key_prev` in 1: pulse; selects the previous track.
- `key_vol_up` in 1: pulse; raises volume by one step.
- `key_vol_dn` in 1: pulse; lowers volume by one step.
- `key_speed` in 1: pulse; cycles the playback speed.
- `key_play` in 1: pulse; toggles play/pause.
- `song_end` in 1: pulse from the player; the current track has finished.
- `order_reg` out 1: 0 = list loop, 1 = single-track repeat.
- `music_reg` out 2: current track, 0..NUM_SONGS.
- `volume_reg` out 3: volume, 1..5.
- `speed_reg` out 2: speed, 0..2.
- `play_reg` out 1: 1 = playing.
- `song_start` out 1: one-cycle pulse; the player restarts the track at `music_reg`.

## Operation
- The state machine has three states, and `play_reg` = (state == PLAY).
  - **IDLE**: `music_reg` = 0.
  - **PAUSE**: a track is selected and stopped.
  - **PLAY**: a track is selected and playing.
- Transitions from **IDLE**:
  - `key_play` → `music_reg` = 1, go to PLAY, `song_start`.
  - `key_next` → `music_reg` = 1, go to PAUSE.
  - `key_prev` → `music_reg` = NUM_SONGS, go to PAUSE.
  - `song_end` is ignored.
- Transitions from **PAUSE**:
  - `key_play` → go to PLAY. No `song_start` is issued; the player resumes.
  - `key_next` / `key_prev` → change track and stay in PAUSE.
- Transitions from **PLAY**:
  - `key_play` → go to PAUSE.
  - `key_next` / `key_prev` → change track, stay in PLAY, `song_start`.
  - `song_end` with `order_reg` = 0 → advance to the next track, `song_start`.
  - `song_end` with `order_reg` = 1 → keep `music_reg`, `song_start`.
- Track arithmetic wraps:
  - next of NUM_SONGS is 1.
  - prev of 1 is NUM_SONGS.
  - 0 is never reached by next/prev.
- Volume saturates:
  - `key_vol_up` at 5 leaves volume at 5.
  - `key_vol_dn` at 1 leaves volume at 1.
  - Both pulses in the same cycle leave volume unchanged.
- Speed sequence: `key_speed` steps 0 → 1 → 2 → 0.
- Order: `key_order` toggles `order_reg`.
- Priority among `key_play`, `key_next`, `key_prev` and `song_end` in one cycle is `key_play` > `key_next` > `key_prev` > `song_end`. Lower-priority pulses in that cycle are dropped.
- Volume, speed and order updates are independent of the track logic and of each other; all apply in the same cycle.

## Timing
- All outputs are registered and change on the clock edge after the input pulse (latency 1).
- `song_start` is high in the same cycle that the new `music_reg` and `play_reg` values first appear, and is low in every other cycle.
- Reset values: `order_reg` = 0, `music_reg` = 0, `volume_reg` = VOL_DEFAULT, `speed_reg` = 0, `play_reg` = 0, `song_start` = 0, state = IDLE.
- `rst` asserted mid-operation overrides every key in that cycle. The next edge produces the reset values, with no `song_start`.
- Input pulses longer than one cycle act once per high cycle. The debouncer upstream guarantees single-cycle pulses.

## Configuration
- Macro: `KEY_CTRL_IDLE_PAUSE_EN`.
- **Defined**:
  - An idle counter counts clocks while the state is PAUSE and no key pulse occurs. Any key pulse, or leaving PAUSE, clears it.
  - When the counter reaches IDLE_CYCLES−1, the next edge moves to IDLE with `music_reg` = 0 and clears the counter.
  - `volume_reg`, `speed_reg` and `order_reg` are kept.
- **Undefined**: no counter is built, and PAUSE persists indefinitely.

## Structure
- A shared package `player_pkg` holds:
  - the state enum (IDLE / PAUSE / PLAY);
  - the constants VOL_MIN = 1, VOL_MAX = 5 and SPEED_MAX = 2;
  - the order encodings ORDER_LIST = 0 and ORDER_REPEAT = 1.
- `output_flag` uses the same constants.
- One sub-module, `idle_timer`, holds the counter and the terminal-count pulse. It is instantiated only under the macro.
- All other logic sits in `key_ctrl_reg`.

## Test plan
- Reset → `music_reg` 0, `volume_reg` 3, `speed_reg` 0, `order_reg` 0, `play_reg` 0. Then `key_play` → next cycle `music_reg` 1, `play_reg` 1, `song_start` high for one cycle.
- In PLAY on track 3 with `order_reg` 0: `song_end` → `music_reg` 1 and `song_start`. Then `key_order`, then `song_end` → `music_reg` stays 1 and `song_start`.
- Six `key_vol_up` pulses from 3 → volume 5. Then six `key_vol_dn` pulses → volume 1. One cycle with both up and down → volume unchanged.
- Three `key_speed` pulses → `speed_reg` 1, 2, 0. In PAUSE, `key_prev` on track 1 → `music_reg` 3 with no `song_start`.
- Same cycle `key_play`, `key_next` and `key_vol_up` in PLAY on track 2 → PAUSE, `music_reg` 2, volume +1. Then `rst` in the same cycle as `key_next` → all reset values.
- With `KEY_CTRL_IDLE_PAUSE_EN` and IDLE_CYCLES 16, in PAUSE on track 2:
  - no keys for 16 cycles → `music_reg` 0 and state IDLE;
  - repeating with a key pulse at cycle 10 → no timeout until 16 cycles after that pulse.

Source files
------------

// File: rtl/player_pkg.sv
// Shared player constants: control-state encoding, volume/speed limits, play-order codes.
// Also used by output_flag so LED decoding agrees with the key controller.
package player_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PAUSE = 2'd1,
    ST_PLAY  = 2'd2
  } play_state_e;

  localparam logic [2:0] VOL_MIN      = 3'd1;
  localparam logic [2:0] VOL_MAX      = 3'd5;
  localparam logic [1:0] SPEED_MAX    = 2'd2;
  localparam logic       ORDER_LIST   = 1'b0;
  localparam logic       ORDER_REPEAT = 1'b1;

  // Track numbers run 1..last and wrap; 0 (no track) is never produced here.
  function automatic logic [1:0] track_next(input logic [1:0] t, input logic [1:0] last);
    return (t >= last) ? 2'd1 : t + 2'd1;
  endfunction

  function automatic logic [1:0] track_prev(input logic [1:0] t, input logic [1:0] last);
    return (t <= 2'd1) ? last : t - 2'd1;
  endfunction

endpackage

// File: rtl/idle_timer.sv
// Paused-idle timeout counter; expire is high in the cycle the count reaches CYCLES-1.
// Only compiled when KEY_CTRL_IDLE_PAUSE_EN is defined.
`ifdef KEY_CTRL_IDLE_PAUSE_EN
module idle_timer #(
  parameter int unsigned CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic count_en,
  output logic expire
);

  localparam int unsigned W  = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] TC = W'(CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign expire = count_en && (cnt_q == TC);

  always_comb begin
    cnt_d = '0;
    if (count_en && !expire) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule
`endif

// File: rtl/key_ctrl_reg.sv
// Key-pulse to held player settings (order/track/volume/speed/play) plus song_start pulse.
// Define KEY_CTRL_IDLE_PAUSE_EN to drop back to IDLE after IDLE_CYCLES untouched in PAUSE.
module key_ctrl_reg
  import player_pkg::*;
#(
  parameter int unsigned NUM_SONGS   = 3,
  parameter int unsigned VOL_DEFAULT = 3,
  parameter int unsigned IDLE_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_order,
  input  logic       key_next,
  input  logic       key_prev,
  input  logic       key_vol_up,
  input  logic       key_vol_dn,
  input  logic       key_speed,
  input  logic       key_play,
  input  logic       song_end,
  output logic       order_reg,
  output logic [1:0] music_reg,
  output logic [2:0] volume_reg,
  output logic [1:0] speed_reg,
  output logic       play_reg,
  output logic       song_start
);

  localparam logic [1:0] LAST = 2'(NUM_SONGS);

  play_state_e state_q, state_d;
  logic [1:0]  music_q, music_d;
  logic [2:0]  vol_q, vol_d;
  logic [1:0]  speed_q, speed_d;
  logic        order_q, order_d;
  logic        start_q, start_d;
  logic        idle_expire;

`ifdef KEY_CTRL_IDLE_PAUSE_EN
  logic any_key;
  assign any_key = key_order | key_next | key_prev | key_vol_up |
                   key_vol_dn | key_speed | key_play;

  idle_timer #(.CYCLES(IDLE_CYCLES)) u_idle_timer (
    .clk      (clk),
    .rst      (rst),
    .count_en ((state_q == ST_PAUSE) && !any_key),
    .expire   (idle_expire)
  );
`else
  logic unused_idle_cfg;
  assign unused_idle_cfg = (IDLE_CYCLES == 0);
  assign idle_expire     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    music_d = music_q;
    vol_d   = vol_q;
    speed_d = speed_q;
    order_d = order_q;
    start_d = 1'b0;

    // Track/state keys: one winner per cycle, the rest are dropped.
    if (key_play) begin
      unique case (state_q)
        ST_IDLE:  begin music_d = 2'd1; state_d = ST_PLAY; start_d = 1'b1; end
        ST_PAUSE: state_d = ST_PLAY;
        default:  state_d = ST_PAUSE;
      endcase
    end else if (key_next) begin
      if (state_q == ST_IDLE) begin
        music_d = 2'd1;
        state_d = ST_PAUSE;
      end else begin
        music_d = track_next(music_q, LAST);
        start_d = (state_q == ST_PLAY);
      end
    end else if (key_prev) begin
      if (state_q == ST_IDLE) begin
        music_d = LAST;
        state_d = ST_PAUSE;
      end else begin
        music_d = track_prev(music_q, LAST);
        start_d = (state_q == ST_PLAY);
      end
    end else if (song_end && state_q == ST_PLAY) begin
      start_d = 1'b1;
      if (order_q != ORDER_REPEAT) music_d = track_next(music_q, LAST);
    end

    // Only fires on a key-free cycle, so it never collides with the branch above.
    if (idle_expire) begin
      state_d = ST_IDLE;
      music_d = 2'd0;
    end

    if (key_vol_up && !key_vol_dn && vol_q != VOL_MAX) vol_d = vol_q + 3'd1;
    if (key_vol_dn && !key_vol_up && vol_q != VOL_MIN) vol_d = vol_q - 3'd1;
    if (key_speed) speed_d = (speed_q == SPEED_MAX) ? 2'd0 : speed_q + 2'd1;
    if (key_order) order_d = ~order_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      music_q <= 2'd0;
      vol_q   <= 3'(VOL_DEFAULT);
      speed_q <= 2'd0;
      order_q <= ORDER_LIST;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      music_q <= music_d;
      vol_q   <= vol_d;
      speed_q <= speed_d;
      order_q <= order_d;
      start_q <= start_d;
    end
  end

  assign order_reg  = order_q;
  assign music_reg  = music_q;
  assign volume_reg = vol_q;
  assign speed_reg  = speed_q;
  assign play_reg   = (state_q == ST_PLAY);
  assign song_start = start_q;

endmodule

// File: tb/tb_key_ctrl_reg.sv
// Scoreboarded random + directed bench for key_ctrl_reg against a rule-level player model.
module tb_key_ctrl_reg;

  localparam int NS   = 3;
  localparam int VOLD = 3;
  localparam int IDLE = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic key_order = 0, key_next = 0, key_prev = 0, key_vol_up = 0;
  logic key_vol_dn = 0, key_speed = 0, key_play = 0, song_end = 0;
  logic       order_reg, play_reg, song_start;
  logic [1:0] music_reg, speed_reg;
  logic [2:0] volume_reg;

  key_ctrl_reg #(.NUM_SONGS(NS), .VOL_DEFAULT(VOLD), .IDLE_CYCLES(IDLE)) dut (
    .clk(clk), .rst(rst),
    .key_order(key_order), .key_next(key_next), .key_prev(key_prev),
    .key_vol_up(key_vol_up), .key_vol_dn(key_vol_dn), .key_speed(key_speed),
    .key_play(key_play), .song_end(song_end),
    .order_reg(order_reg), .music_reg(music_reg), .volume_reg(volume_reg),
    .speed_reg(speed_reg), .play_reg(play_reg), .song_start(song_start)
  );

  typedef struct packed {
    logic       order;
    logic [1:0] music;
    logic [2:0] vol;
    logic [1:0] speed;
    logic       play;
    logic       start;
  } obs_t;

  obs_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Model: mode 0 = no track, 1 = paused, 2 = playing.
  int m_mode, m_track, m_vol, m_speed, m_order, m_idle, m_start;

  localparam int K_ORDER = 0, K_NEXT = 1, K_PREV = 2, K_UP = 3;
  localparam int K_DN = 4, K_SPEED = 5, K_PLAY = 6, K_END = 7;

  function automatic int nxt(input int t);
    return (t == NS) ? 1 : t + 1;
  endfunction
  function automatic int prv(input int t);
    return (t == 1) ? NS : t - 1;
  endfunction

  task automatic apply(input logic [7:0] k, input logic r);
    obs_t e;
    @(negedge clk);
    rst        = r;
    key_order  = k[K_ORDER];
    key_next   = k[K_NEXT];
    key_prev   = k[K_PREV];
    key_vol_up = k[K_UP];
    key_vol_dn = k[K_DN];
    key_speed  = k[K_SPEED];
    key_play   = k[K_PLAY];
    song_end   = k[K_END];
    m_start = 0;
    if (r) begin
      m_mode = 0; m_track = 0; m_vol = VOLD; m_speed = 0; m_order = 0; m_idle = 0;
    end else begin
`ifdef KEY_CTRL_IDLE_PAUSE_EN
      if (m_mode == 1 && k[6:0] == 0) begin
        m_idle++;
        if (m_idle == IDLE) begin
          m_idle = 0; m_mode = 0; m_track = 0;
        end
      end else m_idle = 0;
`endif
      if (k[K_PLAY]) begin
        if (m_mode == 0) begin m_track = 1; m_mode = 2; m_start = 1; end
        else m_mode = (m_mode == 1) ? 2 : 1;
      end else if (k[K_NEXT]) begin
        if (m_mode == 0) begin m_track = 1; m_mode = 1; end
        else begin m_track = nxt(m_track); m_start = (m_mode == 2); end
      end else if (k[K_PREV]) begin
        if (m_mode == 0) begin m_track = NS; m_mode = 1; end
        else begin m_track = prv(m_track); m_start = (m_mode == 2); end
      end else if (k[K_END] && m_mode == 2) begin
        m_start = 1;
        if (m_order == 0) m_track = nxt(m_track);
      end
      if (k[K_UP] && !k[K_DN] && m_vol < 5) m_vol++;
      if (k[K_DN] && !k[K_UP] && m_vol > 1) m_vol--;
      if (k[K_SPEED]) m_speed = (m_speed + 1) % 3;
      if (k[K_ORDER]) m_order = 1 - m_order;
    end
    e.order = 1'(m_order);
    e.music = 2'(m_track);
    e.vol   = 3'(m_vol);
    e.speed = 2'(m_speed);
    e.play  = (m_mode == 2);
    e.start = 1'(m_start);
    exp_q.push_back(e);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) apply(8'h00, 1'b0);
  endtask

  // Monitor: one expected observation per clock edge, checked just after the edge.
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {order_reg, music_reg, volume_reg, speed_reg, play_reg, song_start};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL outputs @%0t: got order=%0d music=%0d vol=%0d speed=%0d play=%0d start=%0d, expected order=%0d music=%0d vol=%0d speed=%0d play=%0d start=%0d",
                   $time, a.order, a.music, a.vol, a.speed, a.play, a.start,
                   e.order, e.music, e.vol, e.speed, e.play, e.start);
        end
      end
    end
  end

  initial begin
    logic [7:0] k;
    apply(8'h00, 1'b1);
    apply(8'h00, 1'b1);
    // Start, go to track 3, list-loop wrap on song_end, then repeat mode.
    apply(8'h40, 1'b0);
    apply(8'h04, 1'b0);
    apply(8'h80, 1'b0);
    apply(8'h01, 1'b0);
    apply(8'h80, 1'b0);
    for (int i = 0; i < 6; i++) apply(8'h08, 1'b0);
    for (int i = 0; i < 6; i++) apply(8'h10, 1'b0);
    apply(8'h18, 1'b0);
    for (int i = 0; i < 3; i++) apply(8'h20, 1'b0);
    // Pause on track 1, prev wraps to 3 silently, then next x2 to track 2.
    apply(8'h40, 1'b0);
    apply(8'h04, 1'b0);
    apply(8'h02, 1'b0);
    apply(8'h02, 1'b0);
    apply(8'h80, 1'b0);
    apply(8'h40, 1'b0);
    apply(8'h4a, 1'b0);
    apply(8'h02, 1'b1);
    apply(8'h00, 1'b0);
    // From IDLE: prev selects last track, song_end ignored in IDLE/PAUSE.
    apply(8'h80, 1'b0);
    apply(8'h04, 1'b0);
    apply(8'h80, 1'b0);
    apply(8'h02, 1'b0);
`ifdef KEY_CTRL_IDLE_PAUSE_EN
    apply(8'h00, 1'b1);
    apply(8'h40, 1'b0);
    apply(8'h02, 1'b0);
    apply(8'h40, 1'b0);
    idle_cycles(IDLE + 1);
    apply(8'h40, 1'b0);
    apply(8'h02, 1'b0);
    apply(8'h40, 1'b0);
    idle_cycles(10);
    apply(8'h20, 1'b0);
    idle_cycles(IDLE + 1);
`endif
    for (int i = 0; i < 2000; i++) begin
      for (int b = 0; b < 8; b++) k[b] = ($urandom_range(0, 5) == 0);
      apply(k, ($urandom_range(0, 99) == 0));
    end
    @(negedge clk);
    key_order = 0; key_next = 0; key_prev = 0; key_vol_up = 0;
    key_vol_dn = 0; key_speed = 0; key_play = 0; song_end = 0;
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected observations never checked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
